// File: rtl/avr_pin_pkg.sv
// Shared definitions for the AVR pin encoder: simulavr pin-state codes and
// the filter state machine encoding.
package avr_pin_pkg;

    typedef logic [2:0] pin_code_t;

    localparam pin_code_t PIN_LOW            = 3'd0;
    localparam pin_code_t PIN_HIGH           = 3'd1;
    localparam pin_code_t PIN_SHORTED        = 3'd2;
    localparam pin_code_t PIN_PULLUP         = 3'd3;
    localparam pin_code_t PIN_TRISTATE       = 3'd4;
    localparam pin_code_t PIN_PULLDOWN       = 3'd5;
    localparam pin_code_t PIN_ANALOG         = 3'd6;
    localparam pin_code_t PIN_ANALOG_SHORTED = 3'd7;

    typedef enum logic {
        FLT_STABLE,
        FLT_QUALIFY
    } filt_state_e;

endpackage

// File: rtl/avr_pin_encoder_if.sv
// Event handshake between the pin encoder and the simulator glue that
// drains committed pin-state changes.
interface avr_pin_encoder_if
    import avr_pin_pkg::*;
();

    logic      evt_valid;
    pin_code_t evt_code;
    logic      evt_ready;

    modport master (
        output evt_valid,
        output evt_code,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        output evt_ready
    );

endinterface

// File: rtl/avr_pin_evt_fifo.sv
// Small event queue for committed pin codes. A push into a full queue is
// accepted only if a pop happens on the same edge; otherwise the new event
// is dropped and the sticky overflow flag is raised.
module avr_pin_evt_fifo
    import avr_pin_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  pin_code_t push_code,
    input  logic      pop,
    output logic      valid,
    output pin_code_t head_code,
    output logic      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] fill;
    pin_code_t   mem_q [DEPTH];
    pin_code_t   mem_d [DEPTH];
    logic        overflow_q, overflow_d;
    logic        empty, full, do_push, do_pop;

    assign fill      = wr_ptr_q - rd_ptr_q;
    assign empty     = (fill == '0);
    assign full      = (fill == FULL_LVL);
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign valid     = ~empty;
    assign head_code = empty ? PIN_TRISTATE : mem_q[rd_ptr_q[AW-1:0]];
    assign overflow  = overflow_q;

    // Next-state for storage, pointers and the sticky drop flag; pop is
    // resolved before push so a full queue can still take a new event.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_code;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !do_push) begin
            overflow_d = 1'b1;
        end
    end

    // Queue registers; reset empties the queue and clears the drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PIN_TRISTATE;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: rtl/avr_pin_encoder.sv
// Verilog-to-AVR pin bridge: synchronises the external pad, encodes the
// simulavr pin-state code, filters it for stability and queues every
// committed change as an event for the simulator glue.
module avr_pin_encoder
    import avr_pin_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               drive_en,
    input  logic               drive_val,
    input  logic               pull_up,
    input  logic               pull_down,
    input  logic               analog_en,
    input  logic               pad_val,
    input  logic               pad_driven,
    output pin_code_t          state_code,
    avr_pin_encoder_if.master  evt,
    output logic [15:0]        change_cnt,
    output logic               overflow
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] pad_val_sync_q, pad_val_sync_d;
    logic [SYNC_STAGES-1:0] pad_drv_sync_q, pad_drv_sync_d;
    logic                   pad_val_s, pad_drv_s, conflict;
    pin_code_t              raw_code;

    filt_state_e            flt_q, flt_d;
    pin_code_t              cand_q, cand_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    pin_code_t              code_q, code_d;
    logic [15:0]            change_cnt_q, change_cnt_d;
    logic                   commit;

    assign pad_val_s  = pad_val_sync_q[SYNC_STAGES-1];
    assign pad_drv_s  = pad_drv_sync_q[SYNC_STAGES-1];
    assign conflict   = pad_drv_s & (pad_val_s != drive_val);
    assign state_code = code_q;
    assign change_cnt = change_cnt_q;

    // Shift the asynchronous pad signals through the synchroniser chain.
    always_comb begin
        pad_val_sync_d = {pad_val_sync_q[SYNC_STAGES-2:0], pad_val};
        pad_drv_sync_d = {pad_drv_sync_q[SYNC_STAGES-2:0], pad_driven};
    end

    // Priority encoder from local controls and synchronised pad to pin code.
    always_comb begin
        raw_code = PIN_TRISTATE;
        if (analog_en && drive_en && conflict) begin
            raw_code = PIN_ANALOG_SHORTED;
        end else if (analog_en) begin
            raw_code = PIN_ANALOG;
        end else if (drive_en && conflict) begin
            raw_code = PIN_SHORTED;
        end else if (drive_en) begin
            raw_code = {2'b00, drive_val};
        end else if (pad_drv_s) begin
            raw_code = {2'b00, pad_val_s};
        end else if (pull_up) begin
            raw_code = PIN_PULLUP;
        end else if (pull_down) begin
            raw_code = PIN_PULLDOWN;
        end
    end

    // Glitch filter: a new code must hold for FILTER_CYCLES edges before it
    // is committed; the commit edge also pushes the event and bumps the count.
    always_comb begin
        flt_d        = flt_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        code_d       = code_q;
        change_cnt_d = change_cnt_q;
        commit       = 1'b0;
        case (flt_q)
            FLT_STABLE: begin
                if (raw_code != code_q) begin
                    if (FILTER_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        flt_d  = FLT_QUALIFY;
                        cand_d = raw_code;
                        cnt_d  = CNT_ONE;
                    end
                end
            end
            FLT_QUALIFY: begin
                if (raw_code == cand_q) begin
                    if (cnt_q + CNT_ONE == CNT_LAST) begin
                        commit = 1'b1;
                        flt_d  = FLT_STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (raw_code == code_q) begin
                    flt_d = FLT_STABLE;
                end else begin
                    cand_d = raw_code;
                    cnt_d  = CNT_ONE;
                end
            end
            default: flt_d = FLT_STABLE;
        endcase
        if (commit) begin
            code_d       = raw_code;
            change_cnt_d = change_cnt_q + 16'd1;
        end
    end

    // Synchroniser, filter and committed-code registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_val_sync_q <= '0;
            pad_drv_sync_q <= '0;
            flt_q          <= FLT_STABLE;
            cand_q         <= PIN_TRISTATE;
            cnt_q          <= '0;
            code_q         <= PIN_TRISTATE;
            change_cnt_q   <= '0;
        end else begin
            pad_val_sync_q <= pad_val_sync_d;
            pad_drv_sync_q <= pad_drv_sync_d;
            flt_q          <= flt_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            code_q         <= code_d;
            change_cnt_q   <= change_cnt_d;
        end
    end

    avr_pin_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (commit),
        .push_code (raw_code),
        .pop       (evt.evt_ready),
        .valid     (evt.evt_valid),
        .head_code (evt.evt_code),
        .overflow  (overflow)
    );

endmodule
